div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle RV32M divider in the EX stage.
- Executes DIV, DIVU, REM and REMU using a radix-2 restoring algorithm.
- It is the responder side of the EX-stage divide stall handshake: it produces div_done_e, and the hazard logic combines that with div_en_e to hold the pipeline.
- Result is muxed into the EX result path when div_done_e=1.

Parameters:
- XLEN, 32, operand and result width.
- EARLY_OUT, 1, enables the 1-cycle fast path for divide-by-zero and signed overflow (0 = always take full latency).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- div_en_e  in  1  EX instruction is a divide/remainder; held high while stalled.
- div_op_e  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a_e  in  XLEN  dividend (forwarded rs1).
- b_e  in  XLEN  divisor (forwarded rs2).
- kill  in  1  abort the current operation (flush/exception); no result.
- div_done_e  out  1  result valid this cycle; pipeline may advance.
- div_result_e  out  XLEN  quotient or remainder; valid only when div_done_e=1.
- div_busy  out  1  FSM not in IDLE (debug/perf counter).

Behaviour:
- Reset: state=IDLE, count=0, div_done_e=0, div_result_e=0, div_busy=0. Internal quotient, remainder and divisor registers cleared.
- Reset asserted mid-operation aborts immediately with no done pulse.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On div_en_e=1 && kill=0, capture the operand magnitudes, the operation, the sign of the quotient (a[XLEN-1]^b[XLEN-1], signed ops only) and the sign of the remainder (a[XLEN-1], signed ops only).
  - If EARLY_OUT and (b==0 or (signed DIV/REM and a==0x80000000 and b==0xFFFFFFFF)), load the special result and go to DONE. Otherwise count=XLEN-1 and go to BUSY.
- BUSY, one step per cycle:
  - rem' = {rem[XLEN-2:0], quo[XLEN-1]}; quo shifted left.
  - If rem' >= divisor (XLEN+1-bit compare), subtract and set quo[0]=1.
  - At count==0, go to DONE; otherwise count decrements.
- DONE:
  - div_done_e=1 for exactly one cycle.
  - div_result_e is the registered quotient or remainder with sign correction applied (two's-complement negate when the sign flag is set).
  - Unconditional return to IDLE.
- Latency: operands sampled in cycle 0 (IDLE); div_done_e=1 in cycle XLEN+1 (cycle 33). Fast path gives div_done_e=1 in cycle 1.
- Special results (RISC-V spec, also produced by the full path when EARLY_OUT=0):
  - DIV/DIVU by 0 gives 0xFFFFFFFF.
  - REM/REMU by 0 gives a.
  - DIV 0x80000000 / -1 gives 0x80000000.
  - REM 0x80000000 / -1 gives 0.
- Back-to-back divides:
  - The stall drops in the DONE cycle, so the next EX instruction appears the following cycle, when the FSM is in IDLE.
  - The FSM samples it then, with no bubble.
  - div_en_e still high in DONE is never treated as a new request.
- Operands are captured only in IDLE; later changes to a_e/b_e while BUSY are ignored.
- kill=1 in any state forces IDLE next cycle and suppresses div_done_e, including in DONE. kill=1 and div_en_e=1 together in IDLE: no start.
- div_done_e is never asserted without a preceding accepted request.

Decomposition:
- Shared CPU package holds:
  - enum div_op_t {DIV, DIVU, REM, REMU} (2 bits, encoding as above);
  - the DIV_LATENCY constant (XLEN+1);
  - the special-value constants (INT_MIN, ALL_ONES).
- One natural sub-module, div_step: a combinational single restoring iteration. It takes rem, quo and divisor and returns the next rem and quo. It is instantiated once and can be re-instantiated for a future radix-4 variant.

Test Plan:
- DIVU a=100, b=7, div_en_e held until done -> div_done_e=1 exactly at cycle 33, div_result_e=14. REMU same operands -> 2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). REM a=7, b=-2 -> 1.
- DIV/DIVU/REM/REMU with b=0, a=0x12345678 -> 0xFFFFFFFF, 0xFFFFFFFF, 0x12345678, 0x12345678. div_done_e at cycle 1 (EARLY_OUT=1), cycle 33 (EARLY_OUT=0).
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -> 0. No exception, done in 1 cycle.
- Two consecutive DIVUs (50/5 then 9/4) with div_en_e continuously high -> done pulses at cycles 33 and 67, results 10 then 2, each pulse one cycle wide.
- kill at cycle 10 of BUSY -> no done pulse, IDLE next cycle, and a new request at cycle 12 completes correctly. rst_n low mid-BUSY -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the EX-stage divider.
package div_unit_pkg;

   localparam int XLEN_DEF = 32;

   // Cycles from request sampling to the done pulse on the full-length path.
   localparam int DIV_LATENCY = XLEN_DEF + 1;

   localparam logic [XLEN_DEF-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [XLEN_DEF-1:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } div_state_t;

   // DIV and REM treat operands as two's complement; the U variants do not.
   function automatic logic op_is_signed(input div_op_t op);
      return ~op[0];
   endfunction

   // REM/REMU return the remainder instead of the quotient.
   function automatic logic op_is_rem(input div_op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration, purely combinational.
// The partial remainder is shifted left taking the next dividend bit from
// the top of the quotient register; if the widened remainder reaches the
// divisor it is reduced and a 1 enters the quotient from the right.
module div_unit_step
   import div_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;
   logic          w_ge;

   // Explicit compare rather than borrow-out: with a zero divisor the
   // remainder is not bounded by the divisor, and every step must subtract.
   always_comb begin
      w_shift = {i_rem, i_quo[XLEN-1]};
      w_diff  = w_shift - {1'b0, i_divisor};
      w_ge    = (w_shift >= {1'b0, i_divisor});
      o_rem   = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      o_quo   = {i_quo[XLEN-2:0], w_ge};
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for div_en_e; operands are only ever sampled here
//   S_BUSY | one restoring step per cycle, r_count steps remaining minus one
//   S_DONE | r_result holds the signed-corrected answer; done pulses once
//
// Divide-by-zero needs no special handling on the full path: every step
// subtracts zero, so the quotient ends all ones and the remainder ends equal
// to the dividend. Only the quotient sign must be suppressed in that case.
// Signed overflow likewise falls out naturally from the magnitudes.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            div_en_e,
   input  logic [1:0]      div_op_e,
   input  logic [XLEN-1:0] a_e,
   input  logic [XLEN-1:0] b_e,
   input  logic            kill,
   output logic            div_done_e,
   output logic [XLEN-1:0] div_result_e,
   output logic            div_busy
);

   localparam int CNT_W = $clog2(XLEN);
   localparam int L_STEPS = (XLEN == XLEN_DEF) ? DIV_LATENCY - 1 : XLEN;
   localparam logic [XLEN-1:0] L_INT_MIN =
      (XLEN == XLEN_DEF) ? XLEN'(INT_MIN) : {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] L_ALL_ONES =
      (XLEN == XLEN_DEF) ? XLEN'(ALL_ONES) : {XLEN{1'b1}};

   div_state_t       r_state;
   div_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [XLEN-1:0]  r_div;
   logic [XLEN-1:0]  r_result;
   logic             r_is_rem;
   logic             r_neg_q;
   logic             r_neg_r;

   div_op_t          w_op;
   logic             w_signed;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [XLEN-1:0]  w_a_mag;
   logic [XLEN-1:0]  w_b_mag;
   logic             w_b_zero;
   logic             w_ovf;
   logic             w_special;
   logic [XLEN-1:0]  w_special_res;
   logic             w_start;
   logic [XLEN-1:0]  w_rem_nxt;
   logic [XLEN-1:0]  w_quo_nxt;
   logic [XLEN-1:0]  w_final;

   div_unit_step #(.XLEN(XLEN)) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_div),
      .o_rem     (w_rem_nxt),
      .o_quo     (w_quo_nxt)
   );

   // Request decode: operand magnitudes, sign flags and the fast-path answer.
   always_comb begin
      w_op      = div_op_t'(div_op_e);
      w_signed  = op_is_signed(w_op);
      w_a_neg   = w_signed & a_e[XLEN-1];
      w_b_neg   = w_signed & b_e[XLEN-1];
      w_a_mag   = w_a_neg ? -a_e : a_e;
      w_b_mag   = w_b_neg ? -b_e : b_e;
      w_b_zero  = (b_e == '0);
      w_ovf     = w_signed && (a_e == L_INT_MIN) && (b_e == L_ALL_ONES);
      w_special = EARLY_OUT && (w_b_zero || w_ovf);
      if (w_b_zero) begin
         w_special_res = op_is_rem(w_op) ? a_e : L_ALL_ONES;
      end else begin
         w_special_res = op_is_rem(w_op) ? '0 : L_INT_MIN;
      end
      w_start = (r_state == S_IDLE) && div_en_e && !kill;
   end

   // Sign-correct the result of the final step on its way into r_result.
   always_comb begin
      if (r_is_rem) begin
         w_final = r_neg_r ? -w_rem_nxt : w_rem_nxt;
      end else begin
         w_final = r_neg_q ? -w_quo_nxt : w_quo_nxt;
      end
   end

   // Next-state logic; kill overrides everything and returns to idle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = w_special ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_count == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (kill) begin
         w_state_nxt = S_IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath: capture on start, iterate while busy, latch the final answer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_result <= '0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else if (w_start) begin
         r_count  <= CNT_W'(L_STEPS - 1);
         r_rem    <= '0;
         r_quo    <= w_a_mag;
         r_div    <= w_b_mag;
         r_is_rem <= op_is_rem(w_op);
         r_neg_q  <= (w_a_neg ^ w_b_neg) && !w_b_zero;
         r_neg_r  <= w_a_neg;
         if (w_special) begin
            r_result <= w_special_res;
         end
      end else if ((r_state == S_BUSY) && !kill) begin
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
         if (r_count == '0) begin
            r_result <= w_final;
         end else begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Done is gated by kill so a flush in the done cycle drops the result.
   always_comb begin
      div_done_e   = (r_state == S_DONE) && !kill;
      div_result_e = div_done_e ? r_result : '0;
      div_busy     = (r_state != S_IDLE);
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: u0 has the fast path, u1 always takes the
// full latency. Expected results are queued at issue, checked at done.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en0 = 1'b0, kill0 = 1'b0, en1 = 1'b0, kill1 = 1'b0;
   logic [1:0]  op0 = 2'b00, op1 = 2'b00;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        done0, busy0, done1, busy1;
   logic [31:0] res0, res1;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       name;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .div_en_e(en0), .div_op_e(op0),
      .a_e(a0), .b_e(b0), .kill(kill0),
      .div_done_e(done0), .div_result_e(res0), .div_busy(busy0)
   );

   div_unit #(.XLEN(32), .EARLY_OUT(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .div_en_e(en1), .div_op_e(op1),
      .a_e(a1), .b_e(b1), .kill(kill1),
      .div_done_e(done1), .div_result_e(res1), .div_busy(busy1)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   task automatic score(input string dut, input logic [31:0] res, input int c, inout exp_t q[$]);
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_unexpected_done: got done with result %h at cycle %0d, required no done", dut, res, c);
      end else begin
         e = q.pop_front();
         chk({dut, "_", e.name, "_result"}, res, e.res);
         checks++;
         if (c != e.cyc) begin
            errors++;
            $display("FAIL %s_%s_cycle: got done at cycle %0d, required %0d", dut, e.name, c, e.cyc);
         end
      end
   endtask

   // Monitors: compare whenever a unit presents div_done_e.
   initial forever begin
      @(negedge clk);
      if (done0) score("u0", res0, cyc, q0);
   end

   initial forever begin
      @(negedge clk);
      if (done1) score("u1", res1, cyc, q1);
   end

   // Issue one request, hold div_en_e until done (bounded), scramble the
   // operands once they have been sampled. Returns #1 after the next edge.
   task automatic run(input bit u, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] want, input int lat,
                      input string name);
      int c0;
      bit seen;
      exp_t e;
      c0 = cyc;
      e.res = want;
      e.cyc = c0 + lat;
      e.name = name;
      if (!u) begin
         en0 = 1'b1; op0 = op; a0 = a; b0 = b; q0.push_back(e);
      end else begin
         en1 = 1'b1; op1 = op; a1 = a; b1 = b; q1.push_back(e);
      end
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (u ? done1 : done0) begin
            seen = 1'b1;
         end else if (cyc > c0) begin
            if (!u) begin a0 = ~a0 ^ i; b0 = 32'(i); end
            else    begin a1 = ~a1 ^ i; b1 = 32'(i); end
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done in 40 cycles, required done at cycle %0d", name, c0 + lat);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      #12;
      chk("reset_done0", {31'b0, done0}, 32'd0);
      chk("reset_res0", res0, 32'd0);
      chk("reset_busy0", {31'b0, busy0}, 32'd0);
      chk("reset_done1", {31'b0, done1}, 32'd0);
      chk("reset_busy1", {31'b0, busy1}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // u0: normal operands, full latency
      run(0, DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
      run(0, REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
      run(0, DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
      run(0, REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
      run(0, REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
      run(0, DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, "div_m100_m7");
      run(0, REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, "rem_m100_m7");
      run(0, DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");
      // u0: fast path
      run(0, DIV, 32'h1234_5678, 32'd0, ALL_ONES, 1, "div_by0");
      run(0, DIVU, 32'h1234_5678, 32'd0, ALL_ONES, 1, "divu_by0");
      run(0, REM, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "rem_by0");
      run(0, REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "remu_by0");
      run(0, DIV, INT_MIN, ALL_ONES, INT_MIN, 1, "div_ovf");
      run(0, REM, INT_MIN, ALL_ONES, 32'd0, 1, "rem_ovf");
      // u0: back-to-back, div_en_e never drops (done at +33 and +67)
      run(0, DIVU, 32'd50, 32'd5, 32'd10, 33, "b2b_first");
      run(0, DIVU, 32'd9, 32'd4, 32'd2, 33, "b2b_second");
      en0 = 1'b0;

      // u1: special operands through the full-length path
      run(1, DIV, 32'h1234_5678, 32'd0, ALL_ONES, 33, "div_by0_full");
      run(1, DIVU, 32'h1234_5678, 32'd0, ALL_ONES, 33, "divu_by0_full");
      run(1, REM, 32'h1234_5678, 32'd0, 32'h1234_5678, 33, "rem_by0_full");
      run(1, REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 33, "remu_by0_full");
      run(1, DIV, 32'hFFFF_FFF9, 32'd0, ALL_ONES, 33, "div_neg_by0_full");
      run(1, REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33, "rem_neg_by0_full");
      run(1, DIV, INT_MIN, ALL_ONES, INT_MIN, 33, "div_ovf_full");
      run(1, REM, INT_MIN, ALL_ONES, 32'd0, 33, "rem_ovf_full");
      en1 = 1'b0;

      // kill mid-BUSY: no done, idle next cycle, new request two cycles later
      c0 = cyc;
      en0 = 1'b1; op0 = DIVU; a0 = 32'd1000; b0 = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      chk("busy_before_kill", {31'b0, busy0}, 32'd1);
      kill0 = 1'b1; en0 = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_kill", {31'b0, busy0}, 32'd0);
      kill0 = 1'b0;
      @(posedge clk); #1;
      chk("restart_cycle", cyc - c0, 32'd12);
      run(0, DIVU, 32'd1000, 32'd3, 32'd333, 33, "after_kill");
      en0 = 1'b0;

      // kill in the DONE cycle suppresses the pulse
      en0 = 1'b1; op0 = DIV; a0 = 32'd5; b0 = 32'd0;
      @(posedge clk); #1;
      en0 = 1'b0; kill0 = 1'b1;
      #1;
      chk("kill_in_done_busy", {31'b0, busy0}, 32'd1);
      chk("kill_in_done_done", {31'b0, done0}, 32'd0);
      @(posedge clk); #1;
      kill0 = 1'b0;
      chk("idle_after_done_kill", {31'b0, busy0}, 32'd0);

      // kill together with a request in IDLE: no start
      en0 = 1'b1; kill0 = 1'b1; op0 = DIVU; a0 = 32'd8; b0 = 32'd2;
      @(posedge clk); #1;
      chk("kill_blocks_start", {31'b0, busy0}, 32'd0);
      en0 = 1'b0; kill0 = 1'b0;
      @(posedge clk); #1;

      // asynchronous reset mid-BUSY
      en0 = 1'b1; op0 = DIVU; a0 = 32'd77; b0 = 32'd5;
      repeat (5) @(posedge clk);
      #1;
      en0 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy_done", {31'b0, done0}, 32'd0);
      chk("rst_mid_busy_res", res0, 32'd0);
      chk("rst_mid_busy_busy", {31'b0, busy0}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run(0, DIVU, 32'd77, 32'd5, 32'd15, 33, "after_reset");
      en0 = 1'b0;

      repeat (4) @(posedge clk);
      #1;
      chk("u0_queue_empty", 32'(q0.size()), 32'd0);
      chk("u1_queue_empty", 32'(q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
